// File: rtl/phi_seq_pkg.sv
// phi_seq_pkg: shared state encoding and default parameters for the phi sequencer
package phi_seq_pkg;
    typedef enum logic [2:0] {PH1, RD, PH2, WR, HALT} phi_state_e;
    localparam int SETTLE_DEF  = 8;
    localparam int RES_PHI_DEF = 8;
    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 8;
    localparam int CW_DEF      = 32;
endpackage

// File: rtl/settle_counter.sv
// settle_counter: load/decrement down-counter flagging when it reaches zero
// Ports: clk, rst (async, active-high), load_i loads load_val_i, dec_i counts down
// (saturating at zero), done_o is high while the count is zero.
module settle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign done_o = cnt_q == '0;
endmodule

// File: rtl/phi_sequencer.sv
// phi_sequencer: generates the CPU phi clock and bridges netlist bus cycles to a req/ack memory port
// Ports: clk/res (async, active-high); run/step control free-run vs single phi cycles;
// ab_in/rw_in/sync_in/dbo_in come from the netlist; phi/cpu_res/dbi go back to it;
// mem_* is a request/acknowledge memory port; sync_q, halted and cycles are status.
module phi_sequencer
    import phi_seq_pkg::*;
#(
    parameter int SETTLE  = SETTLE_DEF,
    parameter int RES_PHI = RES_PHI_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          run,
    input  logic          step,
    input  logic [AW-1:0] ab_in,
    input  logic          rw_in,
    input  logic          sync_in,
    input  logic [DW-1:0] dbo_in,
    output logic          phi,
    output logic          cpu_res,
    output logic [DW-1:0] dbi,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          sync_q,
    output logic          halted,
    output logic [CW-1:0] cycles
);
    localparam int RCW = $clog2(RES_PHI + 2);
    phi_state_e    state_q;
    logic          rw_q, phi_q, cpu_res_q, mem_req_q, mem_we_q, sync_lat_q, halted_q;
    logic [DW-1:0] dbi_q, mem_wdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [CW-1:0] cycles_q;
    logic [RCW-1:0] res_cnt_q;
    logic          timed, done, cyc_end, go_on;
    assign timed = state_q == PH1 || state_q == PH2;
    // Outside the timed phases the counter is held loaded, so every phase starts with a full count.
    settle_counter #(.W(8)) u_settle (
        .clk       (clk),
        .rst       (res),
        .load_i    (!timed || done),
        .dec_i     (timed),
        .load_val_i(8'(SETTLE - 1)),
        .done_o    (done)
    );
    assign cyc_end = (state_q == PH2 && done && rw_q) || (state_q == WR && mem_ack);
    // Post-reset phi cycles keep running regardless of run until the last one completes.
    assign go_on = run || res_cnt_q > RCW'(1);
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= PH1;
            rw_q        <= 1'b0;
            phi_q       <= 1'b0;
            cpu_res_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            sync_lat_q  <= 1'b0;
            halted_q    <= 1'b0;
            dbi_q       <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            cycles_q    <= '0;
            res_cnt_q   <= RCW'(RES_PHI);
        end else begin
            case (state_q)
                PH1: if (done) begin
                    mem_addr_q <= ab_in;
                    rw_q       <= rw_in;
                    sync_lat_q <= sync_in;
                    state_q    <= rw_in ? RD : PH2;
                    phi_q      <= !rw_in;
                    mem_req_q  <= rw_in;
                    mem_we_q   <= 1'b0;
                end
                RD: if (mem_ack) begin
                    dbi_q     <= mem_rdata;
                    mem_req_q <= 1'b0;
                    phi_q     <= 1'b1;
                    state_q   <= PH2;
                end
                PH2: if (done && !rw_q) begin
                    mem_wdata_q <= dbo_in;
                    mem_we_q    <= 1'b1;
                    mem_req_q   <= 1'b1;
                    state_q     <= WR;
                end
                WR: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
                HALT: if (run || step) begin
                    state_q   <= PH1;
                    halted_q  <= 1'b0;
                    cpu_res_q <= 1'b1;
                end
                default: state_q <= PH1;
            endcase
            // End of a phi cycle overrides the per-state next state chosen above.
            if (cyc_end) begin
                cycles_q <= cycles_q + CW'(1);
                if (res_cnt_q != '0) res_cnt_q <= res_cnt_q - RCW'(1);
                state_q  <= go_on ? PH1 : HALT;
                phi_q    <= 1'b0;
                halted_q <= !go_on;
                if (go_on && res_cnt_q <= RCW'(1)) cpu_res_q <= 1'b1;
            end
        end
    end
    assign phi       = phi_q;
    assign cpu_res   = cpu_res_q;
    assign dbi       = dbi_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sync_q    = sync_lat_q;
    assign halted    = halted_q;
    assign cycles    = cycles_q;
endmodule

// File: tb/tb_phi_sequencer.sv
// tb_phi_sequencer: scoreboard bench for phi_sequencer with a delayed-ack memory responder
module tb_phi_sequencer;
    logic        clk, res, run, step, rw_in, sync_in, mem_ack;
    logic [15:0] ab_in;
    logic [7:0]  dbo_in, mem_rdata;
    logic        phi, cpu_res, mem_req, mem_we, sync_q, halted;
    logic [7:0]  dbi, mem_wdata;
    logic [15:0] mem_addr;
    logic [3:0]  cycles;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;
    txn_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    bit sb_en = 0;
    bit ack_tie = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    phi_sequencer #(.SETTLE(4), .RES_PHI(8), .AW(16), .DW(8), .CW(4)) dut (
        .clk(clk), .res(res), .run(run), .step(step), .ab_in(ab_in), .rw_in(rw_in),
        .sync_in(sync_in), .dbo_in(dbo_in), .phi(phi), .cpu_res(cpu_res), .dbi(dbi),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sync_q(sync_q), .halted(halted),
        .cycles(cycles)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Memory responder: checks every request clock against the scoreboard head, acks after ack_delay clocks.
    initial begin
        mem_ack = 0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack = ack_tie;
                wait_cnt = 0;
            end else begin
                if (sb_en) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL bus_unexpected got we=%b addr=%h", mem_we, mem_addr);
                    end else if (mem_we !== sb[0].we || mem_addr !== sb[0].addr ||
                                 (sb[0].we && mem_wdata !== sb[0].data) || phi !== sb[0].we) begin
                        n_err++;
                        $display("FAIL bus_txn got we=%b addr=%h wdata=%h phi=%b expected we=%b addr=%h wdata=%h phi=%b",
                                 mem_we, mem_addr, mem_wdata, phi, sb[0].we, sb[0].addr, sb[0].data, sb[0].we);
                    end
                end
                if (ack_tie || wait_cnt >= ack_delay) begin
                    mem_ack = 1;
                    if (sb_en && sb.size() > 0) void'(sb.pop_front());
                end else begin
                    wait_cnt++;
                    mem_ack = 0;
                end
            end
        end
    end

    task automatic pulse_step();
        @(negedge clk) step = 1;
        @(negedge clk) step = 0;
    endtask

    task automatic wait_halted(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Single-steps one phi cycle, counting request clocks and capturing dbi when phi first rises.
    task automatic run_one(output bit ok, output int req_clks, output logic [7:0] dbi_ph2);
        bit seen_phi;
        seen_phi = 0;
        ok = 0;
        req_clks = 0;
        dbi_ph2 = 8'hxx;
        pulse_step();
        for (int i = 0; i < 400; i++) begin
            if (mem_req) req_clks++;
            if (phi && !seen_phi) begin
                seen_phi = 1;
                dbi_ph2 = dbi;
            end
            if (halted) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        res = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({phi, cpu_res, mem_req, mem_we, halted, sync_q} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got phi,cpu_res,req,we,halted,sync=%b expected 000000",
                     {phi, cpu_res, mem_req, mem_we, halted, sync_q});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, dbi} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got addr=%h wdata=%h dbi=%h expected zeros", mem_addr, mem_wdata, dbi);
        end
        n_cmp++;
        if (cycles !== 4'd0) begin
            n_err++;
            $display("FAIL reset_cycles got %0d expected 0", cycles);
        end
    endtask

    task automatic test_reset_release();
        int phi_rises;
        bit cpu_res_seen, prev_phi, ok;
        phi_rises = 0;
        cpu_res_seen = 0;
        prev_phi = 0;
        ok = 0;
        ack_tie = 1;
        sb_en = 0;
        @(negedge clk) res = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (phi && !prev_phi) phi_rises++;
            prev_phi = phi;
            if (cpu_res) cpu_res_seen = 1;
            if (halted) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL release_halt got halted=0 expected 1 within 1000 clks");
        end
        n_cmp++;
        if (phi_rises != 8) begin
            n_err++;
            $display("FAIL release_phi_count got %0d expected 8", phi_rises);
        end
        n_cmp++;
        if (cycles !== 4'd8) begin
            n_err++;
            $display("FAIL release_cycles got %0d expected 8", cycles);
        end
        n_cmp++;
        if (cpu_res_seen || cpu_res !== 1'b0) begin
            n_err++;
            $display("FAIL release_cpu_res got seen=%b now=%b expected 0", cpu_res_seen, cpu_res);
        end
        ack_tie = 0;
    endtask

    task automatic test_step();
        logic [3:0] c0;
        bit ok;
        c0 = cycles;
        ab_in = 16'h1234;
        rw_in = 1;
        sync_in = 1;
        mem_rdata = 8'h5A;
        ack_delay = 0;
        sb_en = 1;
        sb.push_back('{we: 1'b0, addr: 16'h1234, data: 8'h00});
        pulse_step();
        n_cmp++;
        if (halted !== 1'b0 || cpu_res !== 1'b1) begin
            n_err++;
            $display("FAIL step_leave got halted=%b cpu_res=%b expected halted=0 cpu_res=1", halted, cpu_res);
        end
        repeat (2) @(negedge clk);
        pulse_step();
        wait_halted(ok);
        n_cmp++;
        if (!ok || cycles !== c0 + 4'd1) begin
            n_err++;
            $display("FAIL step_one got ok=%b cycles=%0d expected cycles=%0d", ok, cycles, c0 + 4'd1);
        end
        n_cmp++;
        if (sync_q !== 1'b1 || dbi !== 8'h5A) begin
            n_err++;
            $display("FAIL step_latch got sync_q=%b dbi=%h expected sync_q=1 dbi=5a", sync_q, dbi);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (halted !== 1'b1 || cycles !== c0 + 4'd1) begin
            n_err++;
            $display("FAIL step_ignored got halted=%b cycles=%0d expected halted=1 cycles=%0d",
                     halted, cycles, c0 + 4'd1);
        end
    endtask

    task automatic test_write();
        bit ok;
        int rq;
        logic [7:0] d;
        rw_in = 0;
        ab_in = 16'h0200;
        dbo_in = 8'hA5;
        sync_in = 0;
        ack_delay = 3;
        sb.push_back('{we: 1'b1, addr: 16'h0200, data: 8'hA5});
        run_one(ok, rq, d);
        n_cmp++;
        if (!ok || rq != 4) begin
            n_err++;
            $display("FAIL write_req_clks got ok=%b clks=%0d expected 4", ok, rq);
        end
        n_cmp++;
        if (mem_addr !== 16'h0200 || mem_wdata !== 8'hA5 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL write_bus got addr=%h wdata=%h req=%b expected 0200 a5 0", mem_addr, mem_wdata, mem_req);
        end
        n_cmp++;
        if (dbi !== 8'h5A || sync_q !== 1'b0) begin
            n_err++;
            $display("FAIL write_side got dbi=%h sync_q=%b expected 5a 0", dbi, sync_q);
        end
    endtask

    task automatic test_read();
        bit ok;
        int rq;
        logic [7:0] d;
        rw_in = 1;
        ab_in = 16'h0042;
        mem_rdata = 8'h3C;
        ack_delay = 5;
        sb.push_back('{we: 1'b0, addr: 16'h0042, data: 8'h00});
        run_one(ok, rq, d);
        n_cmp++;
        if (!ok || rq != 6) begin
            n_err++;
            $display("FAIL read_req_clks got ok=%b clks=%0d expected 6", ok, rq);
        end
        n_cmp++;
        if (d !== 8'h3C) begin
            n_err++;
            $display("FAIL read_dbi_at_ph2 got %h expected 3c", d);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got %0d pending expected 0", sb.size());
        end
        sb_en = 0;
    endtask

    task automatic test_free_run();
        bit ok;
        int hi, lo, rq;
        ack_tie = 1;
        rw_in = 1;
        @(negedge clk) run = 1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phi) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL run_start got phi=0 expected a phi rise within 40 clks");
        end
        for (int p = 0; p < 3; p++) begin
            hi = 0;
            lo = 0;
            rq = 0;
            for (int i = 0; i < 50 && phi; i++) begin
                hi++;
                @(negedge clk);
            end
            for (int i = 0; i < 50 && !phi; i++) begin
                lo++;
                if (mem_req) rq++;
                @(negedge clk);
            end
            n_cmp++;
            if (hi != 4 || lo != 5 || rq != 1) begin
                n_err++;
                $display("FAIL run_period%0d got hi=%0d lo=%0d req=%0d expected 4 5 1", p, hi, lo, rq);
            end
        end
        repeat (3) @(negedge clk);
        run = 0;
        wait_halted(ok);
        n_cmp++;
        if (!ok || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL run_stop got ok=%b req=%b expected halted with req=0", ok, mem_req);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int changes;
        logic [3:0] prev;
        ok = 0;
        @(negedge clk) run = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cycles == 4'd15) begin
                ok = 1;
                break;
            end
        end
        for (int i = 0; i < 30 && cycles == 4'd15; i++) @(negedge clk);
        n_cmp++;
        if (!ok || cycles !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_zero got ok=%b cycles=%0d expected 0", ok, cycles);
        end
        changes = 0;
        prev = cycles;
        for (int i = 0; i < 300 && changes < 15; i++) begin
            @(negedge clk);
            if (cycles !== prev) begin
                changes++;
                prev = cycles;
            end
        end
        n_cmp++;
        if (cycles !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_16 got cycles=%0d after %0d changes expected 15", cycles, changes);
        end
        run = 0;
        wait_halted(ok);
        ack_tie = 0;
    endtask

    task automatic test_res_mid_rd();
        bit ok;
        ok = 0;
        rw_in = 1;
        ack_delay = 1000;
        pulse_step();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok || phi !== 1'b0) begin
            n_err++;
            $display("FAIL rd_wait got req_seen=%b phi=%b expected 1 0", ok, phi);
        end
        #2 res = 1;
        #1;
        n_cmp++;
        if ({mem_req, cpu_res, phi} !== 3'b000) begin
            n_err++;
            $display("FAIL res_abort got req,cpu_res,phi=%b expected 000", {mem_req, cpu_res, phi});
        end
        n_cmp++;
        if (cycles !== 4'd0 || mem_addr !== 16'h0) begin
            n_err++;
            $display("FAIL res_abort_state got cycles=%0d addr=%h expected 0 0000", cycles, mem_addr);
        end
        @(negedge clk);
        res = 0;
        ack_delay = 0;
    endtask

    initial begin
        res = 1;
        run = 0;
        step = 0;
        rw_in = 1;
        sync_in = 0;
        ab_in = 16'h0100;
        dbo_in = 8'h00;
        mem_rdata = 8'h00;
        test_reset();
        test_reset_release();
        test_step();
        test_write();
        test_read();
        test_free_run();
        test_wrap();
        test_res_mid_rd();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/phi_sequencer.md
PHI_SEQUENCER -- requirements
Module: phi_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE, default 8: clk cycles per half phase (phi low, phi high); legal range 2..255.
REQ-002 SHALL provide parameter RES_PHI, default 8: number of complete phi cycles cpu_res is held low after reset.
REQ-003 SHALL provide parameter AW, default 16: address width.
REQ-004 SHALL provide parameter DW, default 8: data width.
REQ-005 SHALL provide parameter CW, default 32: phi cycle counter width.
REQ-006 clk  in  1  FPGA clock; the only clock.
REQ-007 res  in  1  reset; asynchronous, active-high.
REQ-008 run  in  1  level; 1 = free-run phi cycles.
REQ-009 step  in  1  one-clk pulse; requests exactly one phi cycle while halted.
REQ-010 ab_in  in  AW  netlist address bus.
REQ-011 rw_in  in  1  netlist rw, 1 = read.
REQ-012 sync_in  in  1  netlist sync.
REQ-013 dbo_in  in  DW  netlist data out.
REQ-014 phi  out  1  CPU clock to the netlist.
REQ-015 cpu_res  out  1  CPU reset, active-low.
REQ-016 dbi  out  DW  registered read data to the netlist.
REQ-017 mem_req  out  1  memory request, held until ack.
REQ-018 mem_we  out  1  1 = write.
REQ-019 mem_addr  out  AW  latched address.
REQ-020 mem_wdata  out  DW  latched write data.
REQ-021 mem_rdata  in  DW  read data, valid with mem_ack.
REQ-022 mem_ack  in  1  completes the request on the clk it is sampled high.
REQ-023 sync_q  out  1  sync latched at the end of phi1.
REQ-024 halted  out  1  1 when in HALT.
REQ-025 cycles  out  CW  completed phi cycles; wraps modulo 2^CW.

Function
REQ-026 States SHALL be PH1 (phi=0), RD (phi=0), PH2 (phi=1), WR (phi=1), HALT (phi=0).
REQ-027 PH1 SHALL last SETTLE clks; on its last clk it latches ab_in->mem_addr, rw_in, sync_in->sync_q; next state RD if rw_in=1, else PH2.
REQ-028 RD SHALL assert mem_req with mem_we=0; on mem_ack, mem_rdata->dbi and next state PH2.
REQ-029 PH2 SHALL last SETTLE clks; on its last clk, if latched rw=0, it latches dbo_in->mem_wdata and goes to WR; otherwise the phi cycle ends.
REQ-030 WR SHALL assert mem_req with mem_we=1 until mem_ack; then the phi cycle ends.
REQ-031 At the end of a phi cycle, cycles SHALL increment; next state PH1 if run=1, else HALT.
REQ-032 HALT SHALL leave PH1 on the clk after run=1 or a step pulse; run=1 dominates step when both are high.
REQ-033 A step pulse outside HALT SHALL be ignored, not queued.
REQ-034 mem_req SHALL be low on the clk after the ack clk; mem_addr, mem_we and mem_wdata SHALL remain stable while mem_req=1.
REQ-035 With mem_ack tied high, a read cycle SHALL take 2*SETTLE+1 clks and a write cycle 2*SETTLE+1 clks.
REQ-036 Deasserting run mid-cycle SHALL complete the current phi cycle, including any pending bus transfer, before HALT.
REQ-037 dbi SHALL change only on a read ack.

Reset
REQ-038 While res=1: state PH1 with count 0, phi=0, cpu_res=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dbi=0, sync_q=0, cycles=0, halted=0.
REQ-039 After res falls, the block SHALL run RES_PHI phi cycles regardless of run; cpu_res SHALL rise at the start of the next PH1.
REQ-040 res asserted mid-transfer SHALL abort the transfer immediately; mem_req drops asynchronously.

Structure
REQ-041 Package phi_seq_pkg SHALL hold the state enum and the default values of SETTLE, RES_PHI, AW, DW and CW.
REQ-042 Sub-module settle_counter SHALL be used: a load/decrement counter with a done flag, instantiated once.

Verification
REQ-043 SETTLE=4, ack tied 1, run=1, rw_in=1: phi low 5 clks, high 4 clks; period 9; one mem_req per cycle.
REQ-044 Reset release, RES_PHI=8, run=0: cpu_res=0 for exactly 8 phi cycles, then halted=1 with cycles=8.
REQ-045 rw_in=0, dbo_in=0xA5, ab_in=0x0200, ack delayed 3 clks: a write with addr 0x0200 and data 0xA5, with phi high throughout WR.
REQ-046 Read of 0x3C with ack delayed 5 clks: phi held low in RD; dbi=0x3C before PH2 begins.
REQ-047 Halted, step pulse together with run=0: exactly one phi cycle, cycles+1, back to HALT; a second step during that cycle is ignored.
REQ-048 CW=4, 16 cycles from 15: cycles wraps to 0; res mid-RD: mem_req=0 and cpu_res=0 immediately.
